inst_fetch_unit: RTL and testbench

//   Fetch-side initiator for the instruction ROM. Owns the PC register and drives
//   the ROM chip-enable and address. Captures the instruction returned by the ROM

---
 rtl/inst_fetch_unit.sv | 121 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, ROM request and IF/ID capture.
// Optional FETCH_PERF_CNT_EN adds fetch and bubble performance counters.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic [31:0] rom_pc_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_bubble_cnt_o,
`endif
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    logic        ce_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        load;

    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        load       = 1'b0;
        if (ce_q) begin
            if (flush_i) begin
                pc_d       = {flush_pc_i[31:2], 2'b00};
                id_pc_d    = 32'd0;
                id_inst_d  = 32'd0;
                id_valid_d = 1'b0;
                pend_vld_d = 1'b0;
            end else if (stall_i) begin
                if (branch_i) begin
                    pend_vld_d = 1'b1;
                    pend_tgt_d = branch_target_i;
                end
            end else begin
                load       = 1'b1;
                id_pc_d    = rom_pc_i;
                id_inst_d  = rom_inst_i;
                id_valid_d = 1'b1;
                pend_vld_d = 1'b0;
                // Current fetch is the delay slot; redirect takes effect next.
                if (branch_i)
                    pc_d = {branch_target_i[31:2], 2'b00};
                else if (pend_vld_q)
                    pc_d = {pend_tgt_q[31:2], 2'b00};
                else
                    pc_d = pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_q       <= 1'b0;
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'd0;
            id_inst_q  <= 32'd0;
            id_valid_q <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'd0;
        end else begin
            ce_q       <= 1'b1;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else if (ce_q) begin
            if (load)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_i || flush_i)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt_o  = fetch_cnt_q;
    assign perf_bubble_cnt_o = bubble_cnt_q;
`else
    logic unused_load;
    assign unused_load = load;
`endif

    assign rom_ce_o   = ce_q;
    assign rom_addr_o = pc_q;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit with a zero-latency ROM model.
// Define FETCH_PERF_CNT_EN to also check the performance counters.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic [31:0] rom_pc_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_bubble_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    assign rom_inst_i = romf(rom_addr_o);
    assign rom_pc_i   = rom_addr_o;

    inst_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .stall_i(stall_i), .branch_i(branch_i),
        .branch_target_i(branch_target_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
        .rom_inst_i(rom_inst_i), .rom_pc_i(rom_pc_i),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt_o(perf_fetch_cnt_o),
        .perf_bubble_cnt_o(perf_bubble_cnt_o),
`endif
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
        .id_valid_o(id_valid_o)
    );

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] bt;
        logic        fl;
        logic [31:0] fp;
        logic [31:0] addr;
        logic [31:0] idpc;
        logic        vld;
    } vec_t;

    typedef struct {
        int          idx;
        logic        ce;
        logic [31:0] addr;
        logic [31:0] idpc;
        logic [31:0] inst;
        logic        vld;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: compare every presented output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk($sformatf("v%0d ce", e.idx), {31'd0, rom_ce_o}, {31'd0, e.ce});
                chk($sformatf("v%0d addr", e.idx), rom_addr_o, e.addr);
                chk($sformatf("v%0d id_pc", e.idx), id_pc_o, e.idpc);
                chk($sformatf("v%0d id_inst", e.idx), id_inst_o, e.inst);
                chk($sformatf("v%0d id_valid", e.idx), {31'd0, id_valid_o}, {31'd0, e.vld});
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // st br bt fl fp | addr idpc vld (state after the edge)
    vec_t vecs[] = '{
        '{0,0,32'h0,0,32'h0, 32'h0,        32'h0,        0},
        '{0,0,32'h0,0,32'h0, 32'h4,        32'h0,        1},
        '{0,0,32'h0,0,32'h0, 32'h8,        32'h4,        1},
        '{1,0,32'h0,0,32'h0, 32'h8,        32'h4,        1},
        '{1,0,32'h0,0,32'h0, 32'h8,        32'h4,        1},
        '{0,0,32'h0,0,32'h0, 32'hC,        32'h8,        1},
        '{0,0,32'h0,0,32'h0, 32'h10,       32'hC,        1},
        '{0,1,32'h40,0,32'h0, 32'h40,      32'h10,       1},
        '{0,0,32'h0,0,32'h0, 32'h44,       32'h40,       1},
        '{0,1,32'h20,0,32'h0, 32'h20,      32'h44,       1},
        '{1,1,32'h80,0,32'h0, 32'h20,      32'h44,       1},
        '{1,0,32'h0,0,32'h0, 32'h20,       32'h44,       1},
        '{1,0,32'h0,0,32'h0, 32'h20,       32'h44,       1},
        '{0,0,32'h0,0,32'h0, 32'h80,       32'h20,       1},
        '{0,0,32'h0,0,32'h0, 32'h84,       32'h80,       1},
        '{1,1,32'h101,0,32'h0, 32'h84,     32'h80,       1},
        '{1,1,32'h203,0,32'h0, 32'h84,     32'h80,       1},
        '{0,0,32'h0,0,32'h0, 32'h200,      32'h84,       1},
        '{0,0,32'h0,0,32'h0, 32'h204,      32'h200,      1},
        '{1,1,32'h300,0,32'h0, 32'h204,    32'h200,      1},
        '{0,1,32'h400,0,32'h0, 32'h400,    32'h204,      1},
        '{0,0,32'h0,0,32'h0, 32'h404,      32'h400,      1},
        '{1,1,32'h500,1,32'h180, 32'h180,  32'h0,        0},
        '{0,0,32'h0,0,32'h0, 32'h184,      32'h180,      1},
        '{0,0,32'h0,1,32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 0},
        '{0,0,32'h0,0,32'h0, 32'h0,        32'hFFFF_FFFC, 1},
        '{0,0,32'h0,0,32'h0, 32'h4,        32'h0,        1}
    };

    initial begin
        exp_t e;
        #12;
        chk("rst ce", {31'd0, rom_ce_o}, 32'd0);
        chk("rst addr", rom_addr_o, 32'h0);
        chk("rst id_valid", {31'd0, id_valid_o}, 32'd0);
        chk("rst id_inst", id_inst_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            stall_i         = vecs[i].st;
            branch_i        = vecs[i].br;
            branch_target_i = vecs[i].bt;
            flush_i         = vecs[i].fl;
            flush_pc_i      = vecs[i].fp;
            e.idx  = i;
            e.ce   = 1'b1;
            e.addr = vecs[i].addr;
            e.idpc = vecs[i].idpc;
            e.vld  = vecs[i].vld;
            e.inst = vecs[i].vld ? romf(vecs[i].idpc) : 32'h0;
            sbq.push_back(e);
        end
        @(negedge clk);
        stall_i = 1'b0; branch_i = 1'b0; flush_i = 1'b0;
        chk("queue drained", sbq.size(), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf fetch", perf_fetch_cnt_o, 32'd16);
        chk("perf bubble", perf_bubble_cnt_o, 32'd10);
`endif
        // Mid-operation reset with a branch pending must drop everything.
        stall_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h700;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst ce", {31'd0, rom_ce_o}, 32'd0);
        chk("midrst addr", rom_addr_o, 32'h0);
        chk("midrst id_pc", id_pc_o, 32'h0);
        chk("midrst id_valid", {31'd0, id_valid_o}, 32'd0);
        stall_i = 1'b0; branch_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post ce", {31'd0, rom_ce_o}, 32'd1);
        chk("post addr0", rom_addr_o, 32'h0);
        @(posedge clk);
        #1;
        chk("post addr1", rom_addr_o, 32'h4);
        chk("post id_pc", id_pc_o, 32'h0);
        chk("post id_valid", {31'd0, id_valid_o}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
